vga_timing_monitor: RTL and testbench
=====================================

// Module: vga_timing_monitor
// PURPOSE
//  Passive checker on the VGA output of top (Hsync, Vsync, Red, Green, Blue).
//  Measures line/frame timing in pixel ticks, flags timing or blanking errors,
//  and produces a per-frame RGB checksum.
//  Instantiated in benches and optionally in hardware for self-test; drives nothing back.
// PARAMETERS
//  H_TOTAL    800  expected pixel ticks per line (hsync assert edge to next)
//  H_SYNC     96   expected hsync pulse width, pixel ticks
//  V_TOTAL    525  expected lines per frame (hsync assert edges per vsync period)
//  V_SYNC     2    expected vsync pulse width, lines
//  SYNC_POL   0    active level of hsync/vsync (0 = active-low)
//  LOCK_FRAMES 2   consecutive good frames required to assert locked
//  CNT_W      12   width of all tick/line counters
// PORTS
//  clk        in   1      system clock (100 MHz)
//  rst        in   1      asynchronous reset, active-high
//  pix_en     in   1      pixel tick strobe (1-in-4 clk for 25 MHz pixel rate)
//  hsync      in   1      Hsync from top
//  vsync      in   1      Vsync from top
//  red        in   4      Red from top
//  green      in   4      Green from top
//  blue       in   4      Blue from top
//  locked     out  1      timing matched for >= LOCK_FRAMES frames
//  frame_done out  1      one-clk pulse at each frame close (vsync assert edge)
//  h_total_m  out  CNT_W  last measured line period, ticks
//  h_sync_m   out  CNT_W  last measured hsync width, ticks
//  v_total_m  out  CNT_W  last measured lines per frame
//  v_sync_m   out  CNT_W  last measured vsync width, lines
//  frame_sum  out  32     RGB checksum of last completed frame
//  err_timing out  1      sticky: any measurement != expected while not SEARCH
//  err_blank  out  1      sticky: nonzero RGB sampled while hsync or vsync active
// BEHAVIOUR
//  - Reset (async, rst=1): all outputs 0, all counters 0, FSM = SEARCH.
//  - All inputs sampled into a register stage only on clk edges with pix_en=1.
//    Edges are found by comparing current with previous sampled value.
//    Everything else ignores cycles with pix_en=0.
//  - Assert edge = sampled sync goes to SYNC_POL.
//    Deassert edge = sampled sync leaves SYNC_POL.
//  - hcnt: +1 per tick; saturates at all-ones, no wrap.
//    On hsync assert edge: h_total_m <= hcnt+1, hcnt <= 0.
//    On hsync deassert edge: h_sync_m <= ticks since assert edge.
//  - lcnt: +1 per hsync assert edge.
//    On vsync assert edge: v_total_m <= lcnt, lcnt <= 0.
//    An hsync assert edge in the same tick counts toward the new frame (lcnt <= 1).
//  - v_sync_m: hsync assert edges seen while vsync is active; latched at vsync deassert edge.
//  - sum: 32-bit accumulator, += {red,green,blue} (12-bit, zero-extended) every tick; wraps mod 2^32.
//    On vsync assert edge: frame_sum <= sum, sum <= pixel of that tick.
//  - Latency: a latched output and frame_done update 1 clk after the pix_en cycle that samples the edge.
//  - FSM, evaluated at each vsync assert edge:
//      SEARCH  -> ACQUIRE unconditionally (first edge; no checks, no frame_done).
//      ACQUIRE -> good frame: good_cnt+1; when good_cnt reaches LOCK_FRAMES -> LOCKED.
//      ACQUIRE -> bad frame: good_cnt <= 0, stay in ACQUIRE.
//      LOCKED  -> bad frame: SEARCH, locked <= 0.
//    Good frame = every h_total_m/h_sync_m latched in that frame matched, plus v_total_m, v_sync_m matched.
//  - Timeout: hcnt reaches 2*H_TOTAL (no hsync) -> SEARCH and locked <= 0 immediately; err_timing set if not in SEARCH.
//  - err_timing is set on any mismatch in ACQUIRE/LOCKED.
//    err_blank is set in any state.
//    Both flags clear only on rst.
//  - locked = 1 only in LOCKED. frame_done pulses in ACQUIRE and LOCKED.
//  - rst mid-frame: everything returns to reset values; the next vsync assert edge restarts acquisition.
// TESTING
//  1 top at 640x480@60, pix_en 1-in-4 -> locked=1 after 3rd vsync edge;
//    h_total_m=800, h_sync_m=96, v_total_m=525, v_sync_m=2; no err.
//  2 Stim gen with one line of 801 ticks in frame 4 -> err_timing=1, locked=0 at that frame close, relock 2 frames later.
//  3 Force red=4'hF during hsync pulse -> err_blank=1, set within 2 clk; lock unaffected.
//  4 Constant RGB 12'h001 for all ticks -> frame_sum = 800*525 = 420000.
//  5 Hold hsync inactive 1600 ticks while locked -> locked=0 at tick 1600, err_timing=1.
//  6 Assert rst mid-frame while locked -> all outputs 0 same cycle;
//    after release, locked returns after SEARCH + LOCK_FRAMES frames.

Source files
------------

// File: rtl/vga_timing_monitor.sv
// Passive VGA timing checker: measures line/frame timing in pixel ticks, tracks
// lock, flags timing/blanking errors and accumulates a per-frame RGB checksum.
module vga_timing_monitor #(
    parameter int          H_TOTAL     = 800,
    parameter int          H_SYNC      = 96,
    parameter int          V_TOTAL     = 525,
    parameter int          V_SYNC      = 2,
    parameter bit          SYNC_POL    = 1'b0,
    parameter int          LOCK_FRAMES = 2,
    parameter int          CNT_W       = 12
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pix_en_i,
    input  logic             hsync_i,
    input  logic             vsync_i,
    input  logic [3:0]       red_i,
    input  logic [3:0]       green_i,
    input  logic [3:0]       blue_i,
    output logic             locked_o,
    output logic             frame_done_o,
    output logic [CNT_W-1:0] h_total_m_o,
    output logic [CNT_W-1:0] h_sync_m_o,
    output logic [CNT_W-1:0] v_total_m_o,
    output logic [CNT_W-1:0] v_sync_m_o,
    output logic [31:0]      frame_sum_o,
    output logic             err_timing_o,
    output logic             err_blank_o
);
    // state    | meaning
    // SEARCH   | no reference yet; waiting for a vsync assert edge
    // ACQUIRE  | checking frames, counting consecutive good ones
    // LOCKED   | LOCK_FRAMES good frames seen; any bad frame drops lock
    typedef enum logic [1:0] {ST_SEARCH, ST_ACQUIRE, ST_LOCKED} state_t;

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_TOT_C  = CNT_W'(H_TOTAL);
    localparam logic [CNT_W-1:0] H_SYN_C  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_TOT_C  = CNT_W'(V_TOTAL);
    localparam logic [CNT_W-1:0] V_SYN_C  = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] TO_M1    = CNT_W'(2 * H_TOTAL - 1);
    localparam logic [7:0]       LOCK_C   = 8'(LOCK_FRAMES);

    state_t            state_q, state_d;
    logic [7:0]        good_q, good_d;
    logic              tick_q, hs_q, hs_prev_q, vs_q, vs_prev_q;
    logic [11:0]       rgb_q;
    logic [CNT_W-1:0]  hcnt_q, hcnt_d, lcnt_q, lcnt_d, vsl_q, vsl_d;
    logic [CNT_W-1:0]  h_total_q, h_total_d, h_sync_q, h_sync_d;
    logic [CNT_W-1:0]  v_total_q, v_total_d, v_sync_q, v_sync_d;
    logic [31:0]       sum_q, sum_d, frame_sum_q, frame_sum_d;
    logic              frame_done_q, frame_done_d, bad_q, bad_d;
    logic              err_t_q, err_t_d, err_b_q, err_b_d;

    logic              hs_act, vs_act, hs_rise, hs_fall, vs_rise, vs_fall;
    logic              checking, timeout, ht_bad, hsw_bad, vsw_bad, vt_bad, frame_bad;
    logic [CNT_W-1:0]  hcnt_p1;

    assign hs_act   = (hs_q == SYNC_POL);
    assign vs_act   = (vs_q == SYNC_POL);
    assign hs_rise  = tick_q &  hs_act & (hs_prev_q != SYNC_POL);
    assign hs_fall  = tick_q & ~hs_act & (hs_prev_q == SYNC_POL);
    assign vs_rise  = tick_q &  vs_act & (vs_prev_q != SYNC_POL);
    assign vs_fall  = tick_q & ~vs_act & (vs_prev_q == SYNC_POL);
    assign hcnt_p1  = hcnt_q + ONE;
    assign timeout  = tick_q & ~hs_rise & (hcnt_q == TO_M1);
    assign ht_bad   = hs_rise & (hcnt_p1 != H_TOT_C);
    assign hsw_bad  = hs_fall & (hcnt_p1 != H_SYN_C);
    assign vsw_bad  = vs_fall & (vsl_q != V_SYN_C);
    assign vt_bad   = vs_rise & (lcnt_q != V_TOT_C);
    assign frame_bad = bad_q | ht_bad | hsw_bad | vt_bad;

    // Inputs are captured on pix_en; everything downstream runs one clk later.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tick_q    <= 1'b0;
            hs_q      <= ~SYNC_POL;
            hs_prev_q <= ~SYNC_POL;
            vs_q      <= ~SYNC_POL;
            vs_prev_q <= ~SYNC_POL;
            rgb_q     <= '0;
        end else begin
            tick_q <= pix_en_i;
            if (pix_en_i) begin
                hs_q      <= hsync_i;
                hs_prev_q <= hs_q;
                vs_q      <= vsync_i;
                vs_prev_q <= vs_q;
                rgb_q     <= {red_i, green_i, blue_i};
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_SEARCH;
            good_q  <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
        end
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        if (timeout) begin
            state_d = ST_SEARCH;
            good_d  = '0;
        end else if (vs_rise) begin
            case (state_q)
                ST_SEARCH: begin
                    state_d = ST_ACQUIRE;
                    good_d  = '0;
                end
                ST_ACQUIRE: begin
                    if (frame_bad) begin
                        good_d = '0;
                    end else if (good_q + 8'd1 == LOCK_C) begin
                        state_d = ST_LOCKED;
                        good_d  = '0;
                    end else begin
                        good_d = good_q + 8'd1;
                    end
                end
                ST_LOCKED: begin
                    if (frame_bad) begin
                        state_d = ST_SEARCH;
                        good_d  = '0;
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end
    end

    always_comb begin
        locked_o = (state_q == ST_LOCKED);
        checking = (state_q != ST_SEARCH);
    end

    always_comb begin
        hcnt_d       = hcnt_q;
        lcnt_d       = lcnt_q;
        vsl_d        = vsl_q;
        h_total_d    = h_total_q;
        h_sync_d     = h_sync_q;
        v_total_d    = v_total_q;
        v_sync_d     = v_sync_q;
        sum_d        = sum_q;
        frame_sum_d  = frame_sum_q;
        frame_done_d = 1'b0;
        bad_d        = bad_q;
        err_t_d      = err_t_q;
        err_b_d      = err_b_q;
        if (tick_q) begin
            hcnt_d = (hcnt_q == '1) ? hcnt_q : hcnt_p1;
            sum_d  = sum_q + {20'd0, rgb_q};
            bad_d  = bad_q | ht_bad | hsw_bad | vsw_bad;
            if (hs_rise) begin
                h_total_d = hcnt_p1;
                hcnt_d    = '0;
                lcnt_d    = (lcnt_q == '1) ? lcnt_q : lcnt_q + ONE;
                if (vs_act) vsl_d = vsl_q + ONE;
            end
            if (hs_fall) h_sync_d = hcnt_p1;
            if (vs_fall) v_sync_d = vsl_q;
            // A coincident hsync edge belongs to the frame that is just starting.
            if (vs_rise) begin
                v_total_d    = lcnt_q;
                lcnt_d       = hs_rise ? ONE : '0;
                vsl_d        = hs_rise ? ONE : '0;
                frame_sum_d  = sum_q;
                sum_d        = {20'd0, rgb_q};
                bad_d        = 1'b0;
                frame_done_d = checking;
            end
            if (checking && (ht_bad || hsw_bad || vsw_bad || vt_bad || timeout)) err_t_d = 1'b1;
            if ((rgb_q != '0) && (hs_act || vs_act)) err_b_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hcnt_q       <= '0;
            lcnt_q       <= '0;
            vsl_q        <= '0;
            h_total_q    <= '0;
            h_sync_q     <= '0;
            v_total_q    <= '0;
            v_sync_q     <= '0;
            sum_q        <= '0;
            frame_sum_q  <= '0;
            frame_done_q <= 1'b0;
            bad_q        <= 1'b0;
            err_t_q      <= 1'b0;
            err_b_q      <= 1'b0;
        end else begin
            hcnt_q       <= hcnt_d;
            lcnt_q       <= lcnt_d;
            vsl_q        <= vsl_d;
            h_total_q    <= h_total_d;
            h_sync_q     <= h_sync_d;
            v_total_q    <= v_total_d;
            v_sync_q     <= v_sync_d;
            sum_q        <= sum_d;
            frame_sum_q  <= frame_sum_d;
            frame_done_q <= frame_done_d;
            bad_q        <= bad_d;
            err_t_q      <= err_t_d;
            err_b_q      <= err_b_d;
        end
    end

    assign frame_done_o = frame_done_q;
    assign h_total_m_o  = h_total_q;
    assign h_sync_m_o   = h_sync_q;
    assign v_total_m_o  = v_total_q;
    assign v_sync_m_o   = v_sync_q;
    assign frame_sum_o  = frame_sum_q;
    assign err_timing_o = err_t_q;
    assign err_blank_o  = err_b_q;
endmodule

// File: tb/tb_vga_timing_monitor.sv
// Scoreboard bench for vga_timing_monitor on a shrunken 20x10-tick raster:
// frame vectors push expected frame-close results, a monitor checks them on frame_done.
module tb_vga_timing_monitor;
    localparam int HT = 20, HS = 3, VT = 10, VS = 2;

    logic        clk = 1'b0, rst = 1'b1, pix_en = 1'b0, hsync = 1'b1, vsync = 1'b1;
    logic [3:0]  red = '0, green = '0, blue = '0;
    logic        locked, frame_done, err_timing, err_blank;
    logic [11:0] h_total_m, h_sync_m, v_total_m, v_sync_m;
    logic [31:0] frame_sum;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int          lines;
        int          extra;
        logic [11:0] rgb;
        int          red_line;
        bit          done;
        bit          lck;
        bit          et;
        bit          eb;
        int          ht;
        int          hsw;
        int          vt;
        int          vsw;
        logic [31:0] sum;
    } vec_t;

    vec_t tbl [15];
    vec_t sb_q [$];

    vga_timing_monitor #(
        .H_TOTAL(HT), .H_SYNC(HS), .V_TOTAL(VT), .V_SYNC(VS),
        .SYNC_POL(1'b0), .LOCK_FRAMES(2), .CNT_W(12)
    ) dut (
        .clk_i(clk), .rst_i(rst), .pix_en_i(pix_en), .hsync_i(hsync), .vsync_i(vsync),
        .red_i(red), .green_i(green), .blue_i(blue),
        .locked_o(locked), .frame_done_o(frame_done),
        .h_total_m_o(h_total_m), .h_sync_m_o(h_sync_m),
        .v_total_m_o(v_total_m), .v_sync_m_o(v_sync_m),
        .frame_sum_o(frame_sum), .err_timing_o(err_timing), .err_blank_o(err_blank)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_locked"}, {31'd0, locked}, 0);
        chk({tag, "_frame_done"}, {31'd0, frame_done}, 0);
        chk({tag, "_h_total"}, {20'd0, h_total_m}, 0);
        chk({tag, "_h_sync"}, {20'd0, h_sync_m}, 0);
        chk({tag, "_v_total"}, {20'd0, v_total_m}, 0);
        chk({tag, "_v_sync"}, {20'd0, v_sync_m}, 0);
        chk({tag, "_frame_sum"}, frame_sum, 0);
        chk({tag, "_err_timing"}, {31'd0, err_timing}, 0);
        chk({tag, "_err_blank"}, {31'd0, err_blank}, 0);
    endtask

    // One pixel tick = 4 clks with pix_en high on the first.
    task automatic tick(input bit probe);
        @(negedge clk);
        if (probe) chk("blank_before", {31'd0, err_blank}, 0);
        pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
        @(negedge clk);
        if (probe) chk("blank_within_2clk", {31'd0, err_blank}, 1);
        @(negedge clk);
    endtask

    task automatic drive_frame(input vec_t v);
        logic [11:0] pix;
        if (v.done) sb_q.push_back(v);
        for (int y = 0; y < v.lines; y++) begin
            for (int x = 0; x < HT + ((y == 3) ? v.extra : 0); x++) begin
                hsync = (x < HS) ? 1'b0 : 1'b1;
                vsync = (y < VS) ? 1'b0 : 1'b1;
                pix   = (y == v.red_line && x < HS) ? 12'hF00 : v.rgb;
                {red, green, blue} = pix;
                tick(y == v.red_line && x == 0);
            end
        end
    endtask

    always @(negedge clk) begin
        if (frame_done) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_frame_done: got 1 expected 0");
            end else begin
                vec_t e;
                e = sb_q.pop_front();
                chk("fd_locked", {31'd0, locked}, {31'd0, e.lck});
                chk("fd_err_timing", {31'd0, err_timing}, {31'd0, e.et});
                chk("fd_err_blank", {31'd0, err_blank}, {31'd0, e.eb});
                chk("fd_h_total", {20'd0, h_total_m}, e.ht);
                chk("fd_h_sync", {20'd0, h_sync_m}, e.hsw);
                chk("fd_v_total", {20'd0, v_total_m}, e.vt);
                chk("fd_v_sync", {20'd0, v_sync_m}, e.vsw);
                chk("fd_frame_sum", frame_sum, e.sum);
            end
        end
    end

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        //            lines ext rgb     red  done lck et eb ht  hsw vt vsw sum
        tbl[0]  = '{10, 0, 12'h000, -1, 0, 0, 0, 0, 0,  0,  0,  0, 0};
        tbl[1]  = '{10, 0, 12'h000, -1, 1, 0, 0, 0, HT, HS, VT, VS, 0};
        tbl[2]  = '{10, 0, 12'h000, -1, 1, 1, 0, 0, HT, HS, VT, VS, 0};
        tbl[3]  = '{10, 1, 12'h000, -1, 1, 1, 0, 0, HT, HS, VT, VS, 0};
        tbl[4]  = '{10, 0, 12'h000, -1, 1, 0, 1, 0, HT, HS, VT, VS, 0};
        tbl[5]  = '{10, 0, 12'h000, -1, 0, 0, 0, 0, 0,  0,  0,  0, 0};
        tbl[6]  = '{10, 0, 12'h000, -1, 1, 0, 1, 0, HT, HS, VT, VS, 0};
        tbl[7]  = '{10, 0, 12'h000,  5, 1, 1, 1, 0, HT, HS, VT, VS, 0};
        tbl[8]  = '{10, 0, 12'h001, -1, 1, 1, 1, 1, HT, HS, VT, VS, 32'd11520};
        tbl[9]  = '{10, 0, 12'h000, -1, 1, 1, 1, 1, HT, HS, VT, VS, 32'd200};
        tbl[10] = '{4,  0, 12'h000, -1, 1, 1, 1, 1, HT, HS, VT, VS, 0};
        tbl[11] = '{10, 0, 12'h000, -1, 0, 0, 0, 0, 0,  0,  0,  0, 0};
        tbl[12] = '{10, 0, 12'h000, -1, 1, 0, 0, 0, HT, HS, VT, VS, 0};
        tbl[13] = '{10, 0, 12'h000, -1, 1, 1, 0, 0, HT, HS, VT, VS, 0};
        tbl[14] = '{2,  0, 12'h000, -1, 1, 1, 0, 0, HT, HS, VT, VS, 0};

        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_locked", {31'd0, locked}, 0);

        for (int i = 0; i <= 10; i++) drive_frame(tbl[i]);

        chk("pre_rst_locked", {31'd0, locked}, 1);
        chk("pre_rst_err_blank", {31'd0, err_blank}, 1);
        rst = 1'b1;
        #1;
        chk_zero("mid_rst");
        chk("mid_rst_queue", sb_q.size(), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 11; i <= 14; i++) drive_frame(tbl[i]);

        chk("pre_to_err_timing", {31'd0, err_timing}, 0);
        chk("pre_to_locked", {31'd0, locked}, 1);
        hsync = 1'b0;
        vsync = 1'b1;
        tick(1'b0);
        hsync = 1'b1;
        for (int t = 1; t < 2 * HT; t++) tick(1'b0);
        chk("to_locked_tick39", {31'd0, locked}, 1);
        tick(1'b0);
        chk("to_locked_tick40", {31'd0, locked}, 0);
        chk("to_err_timing", {31'd0, err_timing}, 1);

        repeat (20) @(negedge clk);
        chk("queue_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
